// File: rtl/qdma_dsc_cpli_ram.sv
// qdma_dsc_cpli_ram: parity-protected descriptor completion-info RAM.
// After reset it clears every entry to zero before accepting traffic. Writes
// are byte-enabled and carry one even-parity bit per 16-bit lane. Parity is
// stored exactly as supplied, so callers can inject errors. Reads return data
// two cycles later and flag single- or multi-lane parity mismatches.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   wadr/wen/wpar/wdat    write port; wen is a per-byte write enable
//   ren/radr              read request
//   rdat/rpar/rvld        read data, stored parity, valid pulse
//   rsbe/rdbe             one lane / two or more lanes mismatched
//   init_done             array initialisation finished
//   sbe_cnt/dbe_cnt       saturating error counters; err_clr clears them

// Parity checker for one lane.
module qdma_dsc_cpli_lane #(
  parameter int LW = 16
) (
  input  logic [LW-1:0] dat,
  input  logic          par,
  output logic          mis
);
  assign mis = (^dat) ^ par;
endmodule

module qdma_dsc_cpli_ram #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 64,
  parameter int PAR_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] wadr,
  input  logic [7:0]        wen,
  input  logic [PAR_W-1:0]  wpar,
  input  logic [DATA_W-1:0] wdat,
  input  logic              ren,
  input  logic [ADDR_W-1:0] radr,
  output logic [DATA_W-1:0] rdat,
  output logic [PAR_W-1:0]  rpar,
  output logic              rsbe,
  output logic              rdbe,
  output logic              rvld,
  output logic              init_done,
  output logic [CNT_W-1:0]  sbe_cnt,
  output logic [CNT_W-1:0]  dbe_cnt,
  input  logic              err_clr
);
  localparam int NB     = 8;
  localparam int LW     = DATA_W / PAR_W;
  localparam int STAGES = 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   init_adr;
  logic [DATA_W-1:0]   mem  [DEPTH];
  logic [PAR_W-1:0]    pmem [DEPTH];

  // FSM: walk the array once, then run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      init_adr  <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= (state == RUN);
      if (state == INIT) begin
        init_adr <= init_adr + ADDR_W'(1);
        if (init_adr == ADDR_W'(DEPTH - 1)) state <= RUN;
      end
    end
  end

  // Write port mux: init sweep owns the array until RUN.
  logic [ADDR_W-1:0] w_adr;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_dat;
  logic [PAR_W-1:0]  w_pbe;
  logic [PAR_W-1:0]  w_par;

  always_comb begin
    w_adr = wadr;
    w_be  = '0;
    w_dat = wdat;
    w_pbe = '0;
    w_par = wpar;
    if (rst_n) begin
      if (state == INIT) begin
        w_adr = init_adr;
        w_be  = '1;
        w_dat = '0;
        w_pbe = '1;
        w_par = '0;
      end else begin
        w_be = wen;
        for (int i = 0; i < PAR_W; i++) w_pbe[i] = wen[2*i] | wen[2*i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (w_be[b]) mem[w_adr][8*b +: 8] <= w_dat[8*b +: 8];
    for (int i = 0; i < PAR_W; i++)
      if (w_pbe[i]) pmem[w_adr][i] <= w_par[i];
  end

  // Read stage 1: array read. Same-edge write lands via NBA, so read-first.
  logic              ren_ok;
  logic [STAGES:1]   vld_pipe;
  logic [DATA_W-1:0] rd_dat;
  logic [PAR_W-1:0]  rd_par;

  assign ren_ok = ren && (state == RUN);

  always_ff @(posedge clk) begin
    if (ren_ok) begin
      rd_dat <= mem[radr];
      rd_par <= pmem[radr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-1:1], ren_ok};
  end

  // Per-lane parity check on the stage-1 data.
  logic [PAR_W-1:0] mis;
  logic             sbe_n, dbe_n;

  for (genvar gi = 0; gi < PAR_W; gi++) begin : g_lane
    qdma_dsc_cpli_lane #(.LW(LW)) u_lane (
      .dat (rd_dat[gi*LW +: LW]),
      .par (rd_par[gi]),
      .mis (mis[gi])
    );
  end

  // x & (x-1) is nonzero exactly when two or more bits are set.
  assign dbe_n = (mis & (mis - PAR_W'(1))) != '0;
  assign sbe_n = (mis != '0) && !dbe_n;

  // Read stage 2: outputs. Data holds between reads; flags do not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdat <= '0;
      rpar <= '0;
      rsbe <= 1'b0;
      rdbe <= 1'b0;
      rvld <= 1'b0;
    end else begin
      rvld <= vld_pipe[1];
      rsbe <= vld_pipe[1] & sbe_n;
      rdbe <= vld_pipe[1] & dbe_n;
      if (vld_pipe[1]) begin
        rdat <= rd_dat;
        rpar <= rd_par;
      end
    end
  end

  // Saturating error counters; clear wins over an increment.
  always_ff @(posedge clk) begin
    if (!rst_n || err_clr) begin
      sbe_cnt <= '0;
      dbe_cnt <= '0;
    end else begin
      if (rsbe && !(&sbe_cnt)) sbe_cnt <= sbe_cnt + CNT_W'(1);
      if (rdbe && !(&dbe_cnt)) dbe_cnt <= dbe_cnt + CNT_W'(1);
    end
  end
endmodule
